// File: rtl/sort_pkg.sv
// Shared types and defaults for the sort result streamer slice.
//   stream_state_e : streamer FSM encoding (idle / streaming a frame)
//   SORT_N_DEFAULT : default elements per frame
//   SORT_W_DEFAULT : default element width in bits
//   idx_w()        : index width for an N-element frame
package sort_pkg;

  typedef enum logic {ST_IDLE, ST_STREAM} stream_state_e;

  localparam int SORT_N_DEFAULT = 8;
  localparam int SORT_W_DEFAULT = 8;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sort_order_checker.sv
// Streaming order checker: compares each accepted beat against the previous one
// and raises a sticky error on an order violation.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the sticky error (start of a new frame)
//   beat       : a beat is being accepted this cycle
//   first      : the accepted beat is beat 0 (nothing to compare against)
//   desc       : 1 = frame must be non-increasing, 0 = non-decreasing
//   data       : element of the accepted beat
//   err        : sticky order-violation flag
module sort_order_checker
  import sort_pkg::*;
#(
  parameter int W = SORT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         beat,
  input  logic         first,
  input  logic         desc,
  input  logic [W-1:0] data,
  output logic         err
);

  logic [W-1:0] prev;
  logic         viol;

  // Equal neighbours are legal in both directions.
  always_comb begin
    viol = 1'b0;
    if (beat && !first) begin
      viol = desc ? (prev < data) : (prev > data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      err  <= 1'b0;
    end else begin
      if (beat) begin
        prev <= data;
      end
      if (clr) begin
        err <= 1'b0;
      end else if (viol) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sort_result_streamer.sv
// Transmit side for the sorter's parallel output: captures one N-element frame in
// a single handshake and streams it beat by beat, ascending or descending.
//   clk, rst_n             : clock, asynchronous active-low reset
//   load_valid/load_ready  : frame capture handshake
//   load_data [0:N-1]      : sorted-ascending frame from the sorter
//   load_desc              : 1 = send N-1..0, 0 = send 0..N-1
//   out_valid/out_ready    : beat handshake
//   out_data/out_idx/out_last : beat element, beat number, last-beat flag
//   busy                   : a frame is in flight
//   order_err              : sticky per frame, order violation seen
module sort_result_streamer
  import sort_pkg::*;
#(
  parameter  int N  = SORT_N_DEFAULT,
  parameter  int W  = SORT_W_DEFAULT,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  load_data [0:N-1],
  input  logic          load_desc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          order_err
);

  stream_state_e state;
  logic [W-1:0]  buffer [0:N-1];
  logic          desc_q;
  logic          clr_pend;

  logic          handshake;
  logic          load_acc;
  logic          last_hs;
  logic [IW-1:0] nxt_k;
  logic [IW-1:0] nxt_addr;
  logic          chk_clr;

  assign handshake  = out_valid && out_ready;
  assign last_hs    = handshake && out_last;
  assign load_ready = (state == ST_IDLE) || last_hs;
  assign load_acc   = load_valid && load_ready;
  assign busy       = (state == ST_STREAM);

  // out_idx doubles as the beat counter; the buffer address is mirrored for desc.
  always_comb begin
    nxt_k    = out_idx + 1'b1;
    nxt_addr = desc_q ? (IW'(N - 1) - nxt_k) : nxt_k;
  end

  always_ff @(posedge clk) begin
    if (load_acc) begin
      buffer <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      desc_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      clr_pend  <= 1'b0;
    end else begin
      clr_pend <= load_acc && last_hs;
      if (load_acc) begin
        state     <= ST_STREAM;
        desc_q    <= load_desc;
        out_valid <= 1'b1;
        out_idx   <= '0;
        out_last  <= 1'b0;
        out_data  <= load_desc ? load_data[N-1] : load_data[0];
      end else if (handshake) begin
        if (out_last) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end else begin
          out_idx  <= nxt_k;
          out_last <= (nxt_k == IW'(N - 1));
          out_data <= buffer[nxt_addr];
        end
      end
    end
  end

  // A back-to-back load keeps the old frame's final compare visible for one
  // cycle, so its clear is deferred by one edge via clr_pend.
  assign chk_clr = (load_acc && !last_hs) || clr_pend;

  sort_order_checker #(
    .W(W)
  ) u_checker (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (chk_clr),
    .beat  (handshake),
    .first (out_idx == '0),
    .desc  (desc_q),
    .data  (out_data),
    .err   (order_err)
  );

endmodule

// File: tb/tb_sort_result_streamer.sv
module tb_sort_result_streamer;

  localparam int N = 8;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic [2:0]   idx;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] load_data [0:N-1];
  logic         load_desc = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [2:0]   out_idx;
  logic         out_last;
  logic         busy;
  logic         order_err;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int accepts = 0;

  beat_t        sb[$];
  logic         hold_pending = 1'b0;
  logic [W-1:0] hold_data;
  logic [2:0]   hold_idx;
  logic         hold_last;

  always #5 clk = ~clk;

  sort_result_streamer #(
    .N(N),
    .W(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_desc  (load_desc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy),
    .order_err  (order_err)
  );

  // One clock: sample at negedge (scoreboard pop, stall hold, load push), then step past posedge.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    if (rst_n) begin
      if (hold_pending) begin
        checks++;
        if (out_data !== hold_data || out_idx !== hold_idx || out_last !== hold_last) begin
          errors++;
          $display("FAIL stall_hold: got data=%0d idx=%0d last=%0b, required data=%0d idx=%0d last=%0b",
                   out_data, out_idx, out_last, hold_data, hold_idx, hold_last);
        end
      end
      if (out_valid && out_ready) begin
        beats++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%0d idx=%0d, required no beat", out_data, out_idx);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_idx !== e.idx || out_last !== e.last) begin
            errors++;
            $display("FAIL beat: got data=%0d idx=%0d last=%0b, required data=%0d idx=%0d last=%0b",
                     out_data, out_idx, out_last, e.data, e.idx, e.last);
          end
        end
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      hold_idx     = out_idx;
      hold_last    = out_last;
      if (load_valid && load_ready) begin
        accepts++;
        for (int k = 0; k < N; k++) begin
          e.data = load_desc ? load_data[N-1-k] : load_data[k];
          e.idx  = 3'(k);
          e.last = (k == N - 1);
          sb.push_back(e);
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input logic [W-1:0] d [0:N-1], input logic desc, output bit ok);
    int a0;
    int n;
    a0 = accepts;
    n = 0;
    load_data  = d;
    load_desc  = desc;
    load_valid = 1'b1;
    while (accepts == a0 && n < 50) begin
      tick();
      n++;
    end
    load_valid = 1'b0;
    ok = (accepts != a0);
  endtask

  task automatic drain(input int budget, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (out_valid || sb.size() != 0) begin
      if (n >= budget) begin
        ok = 1'b0;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0 ||
        out_last !== 1'b0 || busy !== 1'b0 || order_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ready=%0b valid=%0b data=%0d idx=%0d last=%0b busy=%0b err=%0b, required 1 0 0 0 0 0 0",
               load_ready, out_valid, out_data, out_idx, out_last, busy, order_err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ascending();
    logic [W-1:0] d [0:N-1];
    bit ok;
    d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    out_ready = 1'b1;
    load_frame(d, 1'b0, ok);
    checks++;
    if (!ok || out_valid !== 1'b1 || out_data !== 8'd1 || out_idx !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL asc_first_beat: got acc=%0b valid=%0b data=%0d idx=%0d busy=%0b, required 1 1 1 0 1",
               ok, out_valid, out_data, out_idx, busy);
    end
    for (int i = 0; i < N; i++) tick();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0 || order_err !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL asc_end: got valid=%0b pending=%0d err=%0b ready=%0b, required 0 0 0 1",
               out_valid, sb.size(), order_err, load_ready);
    end
  endtask

  task automatic test_descending();
    logic [W-1:0] d [0:N-1];
    bit ok;
    d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    out_ready = 1'b1;
    load_frame(d, 1'b1, ok);
    checks++;
    if (!ok || out_data !== 8'd8 || out_idx !== 3'd0) begin
      errors++;
      $display("FAIL desc_first_beat: got acc=%0b data=%0d idx=%0d, required 1 8 0", ok, out_data, out_idx);
    end
    for (int i = 0; i < N; i++) tick();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0 || order_err !== 1'b0) begin
      errors++;
      $display("FAIL desc_end: got valid=%0b pending=%0d err=%0b, required 0 0 0",
               out_valid, sb.size(), order_err);
    end
  endtask

  task automatic test_order_err();
    logic [W-1:0] d [0:N-1];
    bit ok;
    d = '{8'd1, 8'd3, 8'd2, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    out_ready = 1'b1;
    load_frame(d, 1'b0, ok);
    tick();
    tick();
    checks++;
    if (!ok || out_idx !== 3'd2 || order_err !== 1'b0) begin
      errors++;
      $display("FAIL order_err_before: got acc=%0b idx=%0d err=%0b, required 1 2 0", ok, out_idx, order_err);
    end
    tick();
    checks++;
    if (order_err !== 1'b1) begin
      errors++;
      $display("FAIL order_err_rise: got err=%0b, required 1", order_err);
    end
    drain(20, ok);
    checks++;
    if (!ok || order_err !== 1'b1) begin
      errors++;
      $display("FAIL order_err_sticky: got drained=%0b err=%0b, required 1 1", ok, order_err);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] d [0:N-1];
    bit ok;
    int b0;
    int n;
    d = '{8'd10, 8'd20, 8'd20, 8'd40, 8'd90, 8'd91, 8'd200, 8'd255};
    out_ready = 1'b0;
    load_frame(d, 1'b0, ok);
    checks++;
    if (!ok || order_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_load: got acc=%0b err=%0b, required 1 0", ok, order_err);
    end
    b0 = beats;
    n = 0;
    while ((out_valid || sb.size() != 0) && n < 300) begin
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
      n++;
    end
    out_ready = 1'b1;
    checks++;
    if (n >= 300 || beats - b0 != N || order_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_frame: got beats=%0d err=%0b cycles=%0d, required beats=%0d err=0",
               beats - b0, order_err, n, N);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a [0:N-1];
    logic [W-1:0] b [0:N-1];
    int a0;
    int n;
    bit ok;
    a = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    b = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
    out_ready  = 1'b1;
    load_desc  = 1'b0;
    load_data  = a;
    load_valid = 1'b1;
    tick();
    load_data = b;
    a0 = accepts;
    n = 0;
    while (accepts == a0 && n < 30) begin
      if (load_ready) begin
        checks++;
        if (out_idx !== 3'd7 || out_last !== 1'b1 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_point: got idx=%0d last=%0b valid=%0b, required 7 1 1",
                   out_idx, out_last, out_valid);
        end
      end
      tick();
      n++;
    end
    load_valid = 1'b0;
    checks++;
    if (accepts == a0 || out_valid !== 1'b1 || out_idx !== 3'd0 || out_data !== 8'd7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_bubble: got acc=%0d valid=%0b idx=%0d data=%0d busy=%0b, required 1 1 0 7 1",
               accepts - a0, out_valid, out_idx, out_data, busy);
    end
    drain(20, ok);
    checks++;
    if (!ok || order_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got drained=%0b err=%0b, required 1 0", ok, order_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d [0:N-1];
    bit ok;
    d = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    out_ready = 1'b1;
    load_frame(d, 1'b0, ok);
    tick();
    tick();
    tick();
    checks++;
    if (!ok || out_idx !== 3'd3 || out_data !== 8'd6) begin
      errors++;
      $display("FAIL mid_beat3: got acc=%0b idx=%0d data=%0d, required 1 3 6", ok, out_idx, out_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%0b busy=%0b idx=%0d last=%0b, required 0 0 0 0",
               out_valid, busy, out_idx, out_last);
    end
    sb.delete();
    hold_pending = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready_after: got ready=%0b, required 1", load_ready);
    end
    load_frame(d, 1'b1, ok);
    checks++;
    if (!ok || out_idx !== 3'd0 || out_data !== 8'd10) begin
      errors++;
      $display("FAIL mid_restart: got acc=%0b idx=%0d data=%0d, required 1 0 10", ok, out_idx, out_data);
    end
    drain(20, ok);
    checks++;
    if (!ok || order_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart_end: got drained=%0b err=%0b, required 1 0", ok, order_err);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) load_data[i] = '0;
    test_reset();
    test_ascending();
    test_descending();
    test_order_err();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
